// File: rtl/data_pack_pkg.sv
// Shared definitions for the 64->128 pixel packer: FSM encodings and fval delay depth.
package data_pack_pkg;

  localparam int unsigned FVAL_DLY = 2;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/data_pack_fval_edge_det.sv
// Frame-valid edge detector: registered fval plus combinational rise/fall strobes.
module fval_edge_det (
  input  logic clk_pix,
  input  logic reset_pix,
  input  logic i_fval,
  output logic o_rise,
  output logic o_fall,
  output logic o_fval_d1
);

  always_ff @(posedge clk_pix or posedge reset_pix) begin
    if (reset_pix) o_fval_d1 <= 1'b0;
    else           o_fval_d1 <= i_fval;
  end

  assign o_rise = i_fval & ~o_fval_d1;
  assign o_fall = ~i_fval & o_fval_d1;

endmodule

// File: rtl/data_pack.sv
// 64->128 frame-aware width up-converter; odd trailing word is flushed padded at fval fall.
// Optional per-frame output word counter enabled by DATA_PACK_STAT_EN.
module data_pack
  import data_pack_pkg::*;
#(
  parameter int unsigned               DATA_WD_64  = 64,
  parameter int unsigned               DATA_WD_128 = 128,
  parameter logic [DATA_WD_64-1:0]     PAD_VALUE   = '0
) (
  input  logic                   clk_pix,
  input  logic                   reset_pix,
  input  logic                   i_fval,
  input  logic                   i_data_valid,
  input  logic [DATA_WD_64-1:0]  iv_data,
  output logic                   o_fval,
  output logic                   o_data_valid,
  output logic [DATA_WD_128-1:0] ov_data,
  output logic                   o_pad
`ifdef DATA_PACK_STAT_EN
  ,
  output logic [15:0]            ov_word_cnt
`endif
);

  pack_state_e             state;
  logic [DATA_WD_64-1:0]   hold_lo;
  logic                    fval_rise;
  logic                    fval_fall;
  logic                    fval_d1;
  logic [FVAL_DLY-2:0]     fval_sr;
  logic                    accept;

  fval_edge_det u_fval_edge_det (
    .clk_pix   (clk_pix),
    .reset_pix (reset_pix),
    .i_fval    (i_fval),
    .o_rise    (fval_rise),
    .o_fall    (fval_fall),
    .o_fval_d1 (fval_d1)
  );

  assign accept = i_fval & i_data_valid;

  // Remaining fval delay stages continue on from the edge detector's first stage.
  always_ff @(posedge clk_pix or posedge reset_pix) begin
    if (reset_pix) fval_sr <= '0;
    else           fval_sr <= (FVAL_DLY-1)'({fval_sr, fval_d1});
  end

  assign o_fval = fval_sr[FVAL_DLY-2];

  always_ff @(posedge clk_pix or posedge reset_pix) begin
    if (reset_pix) begin
      state        <= ST_EMPTY;
      hold_lo      <= '0;
      ov_data      <= '0;
      o_data_valid <= 1'b0;
      o_pad        <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_pad        <= 1'b0;
      if (accept) begin
        // A rising fval restarts pairing, so the accepted word becomes the new low half.
        if (state == ST_HALF && !fval_rise) begin
          ov_data      <= {iv_data, hold_lo};
          o_data_valid <= 1'b1;
          state        <= ST_EMPTY;
        end else begin
          hold_lo <= iv_data;
          state   <= ST_HALF;
        end
      end else if (fval_rise) begin
        state <= ST_EMPTY;
      end else if (fval_fall && state == ST_HALF) begin
        ov_data      <= {PAD_VALUE, hold_lo};
        o_data_valid <= 1'b1;
        o_pad        <= 1'b1;
        state        <= ST_EMPTY;
      end
    end
  end

`ifdef DATA_PACK_STAT_EN
  logic o_fval_q;

  // A word leaving in the o_fval rise cycle is the first of the new frame.
  always_ff @(posedge clk_pix or posedge reset_pix) begin
    if (reset_pix) begin
      o_fval_q    <= 1'b0;
      ov_word_cnt <= '0;
    end else begin
      o_fval_q <= o_fval;
      if (o_fval && !o_fval_q)
        ov_word_cnt <= {15'd0, o_data_valid};
      else if (o_data_valid && ov_word_cnt != 16'hFFFF)
        ov_word_cnt <= ov_word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_pack.sv
// Self-checking bench for data_pack: per-cycle vector table plus scoreboarded frame sequences.
module tb_data_pack;

  localparam logic [63:0] PAD = '0;

  logic         clk_pix = 1'b0;
  logic         reset_pix;
  logic         i_fval;
  logic         i_data_valid;
  logic [63:0]  iv_data;
  logic         o_fval;
  logic         o_data_valid;
  logic [127:0] ov_data;
  logic         o_pad;
`ifdef DATA_PACK_STAT_EN
  logic [15:0]  ov_word_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [127:0] data;
    logic         pad;
  } exp_t;

  typedef struct {
    logic         f;
    logic         v;
    logic [63:0]  d;
    logic         odv;
    logic         ofv;
    logic         pad;
    logic [127:0] data;
  } row_t;

  exp_t  sb[$];
  int    out_cyc[$];
  row_t  tbl[7];

  // Reference pairing model state
  bit          m_half   = 1'b0;
  bit          m_prev_f = 1'b0;
  logic [63:0] m_held   = '0;

  data_pack dut (
    .clk_pix      (clk_pix),
    .reset_pix    (reset_pix),
    .i_fval       (i_fval),
    .i_data_valid (i_data_valid),
    .iv_data      (iv_data),
    .o_fval       (o_fval),
    .o_data_valid (o_data_valid),
    .ov_data      (ov_data),
    .o_pad        (o_pad)
`ifdef DATA_PACK_STAT_EN
    ,
    .ov_word_cnt  (ov_word_cnt)
`endif
  );

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_pix) begin
    if (!reset_pix) begin
      if (o_data_valid) begin
        exp_t e;
        chk("valid_inside_fval", o_fval, 1'b1);
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_output", ov_data, '1);
        end else begin
          e = sb.pop_front();
          chk("sb_data", ov_data, e.data);
          chk("sb_pad", o_pad, e.pad);
        end
      end else if (o_pad) begin
        chk("pad_without_valid", o_pad, 1'b0);
      end
    end
  end

  // Drive one cycle of inputs; the model pushes whatever the DUT must emit after this edge.
  task automatic drive(input bit f, input bit v, input logic [63:0] d);
    bit rise;
    rise = f && !m_prev_f;
    if (f && v) begin
      if (m_half && !rise) begin
        sb.push_back('{data: {d, m_held}, pad: 1'b0});
        m_half = 1'b0;
      end else begin
        m_held = d;
        m_half = 1'b1;
      end
    end else if (rise) begin
      m_half = 1'b0;
    end else if (!f && m_prev_f && m_half) begin
      sb.push_back('{data: {PAD, m_held}, pad: 1'b1});
      m_half = 1'b0;
    end
    m_prev_f     = f;
    i_fval       = f;
    i_data_valid = v;
    iv_data      = d;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_pix);
    @(negedge clk_pix);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    tbl[0] = '{f:1'b0, v:1'b1, d:64'hDEAD, odv:1'b0, ofv:1'b0, pad:1'b0, data:'0};
    tbl[1] = '{f:1'b1, v:1'b1, d:64'hA, odv:1'b0, ofv:1'b0, pad:1'b0, data:'0};
    tbl[2] = '{f:1'b1, v:1'b1, d:64'hB, odv:1'b1, ofv:1'b1, pad:1'b0, data:{64'hB, 64'hA}};
    tbl[3] = '{f:1'b1, v:1'b1, d:64'hC, odv:1'b0, ofv:1'b1, pad:1'b0, data:'0};
    tbl[4] = '{f:1'b0, v:1'b0, d:64'h0, odv:1'b1, ofv:1'b1, pad:1'b1, data:{PAD, 64'hC}};
    tbl[5] = '{f:1'b0, v:1'b1, d:64'hDEAD, odv:1'b0, ofv:1'b0, pad:1'b0, data:'0};
    tbl[6] = '{f:1'b0, v:1'b0, d:64'h0, odv:1'b0, ofv:1'b0, pad:1'b0, data:'0};

    reset_pix    = 1'b1;
    i_fval       = 1'b0;
    i_data_valid = 1'b0;
    iv_data      = '0;
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    chk("rst_o_fval", o_fval, 1'b0);
    chk("rst_o_data_valid", o_data_valid, 1'b0);
    chk("rst_o_pad", o_pad, 1'b0);
    chk("rst_ov_data", ov_data, '0);
    reset_pix = 1'b0;
    repeat (2) drive(1'b0, 1'b0, '0);

    // Eight back-to-back words
    out_cyc.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 64'(i));
      if (i == 1) chk("t1_o_fval_lag1", o_fval, 1'b0);
      if (i == 2) chk("t1_o_fval_lag2", o_fval, 1'b1);
    end
    drive(1'b0, 1'b0, '0);
    drain("t1_drain");
    chk("t1_out_count", out_cyc.size(), 4);
    for (int i = 1; i < out_cyc.size(); i++)
      chk("t1_spacing", out_cyc[i] - out_cyc[i-1], 2);
    repeat (3) drive(1'b0, 1'b0, '0);

    // Three-word frame with stray valids outside fval, cycle by cycle
    for (int r = 0; r < 7; r++) begin
      drive(tbl[r].f, tbl[r].v, tbl[r].d);
      @(negedge clk_pix);
      chk($sformatf("tbl%0d_odv", r), o_data_valid, tbl[r].odv);
      chk($sformatf("tbl%0d_ofv", r), o_fval, tbl[r].ofv);
      chk($sformatf("tbl%0d_pad", r), o_pad, tbl[r].pad);
      if (tbl[r].odv) chk($sformatf("tbl%0d_data", r), ov_data, tbl[r].data);
    end
    drain("t2_drain");
    repeat (2) drive(1'b0, 1'b0, '0);

    // 0xDEAD valids around a frame must not disturb pairing
    repeat (2) drive(1'b0, 1'b1, 64'hDEAD);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 64'h11 + 64'(i));
    drive(1'b0, 1'b1, 64'hDEAD);
    drive(1'b0, 1'b1, 64'hDEAD);
    drain("t3_drain");
    repeat (2) drive(1'b0, 1'b0, '0);

    // Gapped valid: 1 on, 3 off
    out_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 64'h4000 + 64'(i));
      repeat (3) drive(1'b1, 1'b0, 64'hBAD);
    end
    drive(1'b0, 1'b0, '0);
    drain("t4_drain");
    chk("t4_out_count", out_cyc.size(), 3);
    repeat (2) drive(1'b0, 1'b0, '0);

    // Asynchronous reset while holding a half word
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 64'h51 + 64'(i));
    #2;
    reset_pix = 1'b1;
    #1;
    chk("t5_o_fval", o_fval, 1'b0);
    chk("t5_o_data_valid", o_data_valid, 1'b0);
    chk("t5_o_pad", o_pad, 1'b0);
    chk("t5_ov_data", ov_data, '0);
    sb.delete();
    m_half       = 1'b0;
    m_prev_f     = 1'b0;
    i_fval       = 1'b0;
    i_data_valid = 1'b0;
    repeat (2) @(posedge clk_pix);
    #1;
    reset_pix = 1'b0;
    out_cyc.delete();
    repeat (3) drive(1'b0, 1'b0, '0);
    chk("t5_no_flush", out_cyc.size(), 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 64'h61 + 64'(i));
    drive(1'b0, 1'b0, '0);
    drain("t5_drain");
    repeat (2) drive(1'b0, 1'b0, '0);

`ifdef DATA_PACK_STAT_EN
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 64'h700 + 64'(i));
    repeat (5) drive(1'b0, 1'b0, '0);
    chk("t6_cnt_frame1", ov_word_cnt, 3);
    repeat (3) drive(1'b1, 1'b0, '0);
    chk("t6_cnt_cleared", ov_word_cnt, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 64'h800 + 64'(i));
    repeat (5) drive(1'b0, 1'b0, '0);
    chk("t6_cnt_frame2", ov_word_cnt, 2);
    drain("t6_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
